dmem_stall_responder: RTL
=========================

Name: dmem_stall_responder

Overview:
Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline. It answers the pipeline's memRead/memWrite requests. It drives the pipeline-wide hold line to freeze the pipe registers until the access completes, and it presents read data for one cycle so MEM/WB can capture it. It replaces the single-cycle data memory. Stage control/data registers connect unchanged.

Parameters:
ADDR_W, 8, word-address width; array depth is 2**ADDR_W 32-bit words
LATENCY, 2, stall cycles per access; legal range 1..15

Ports:
clk  input  1  pipeline clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
memRead  input  1  read request from EX/MEM control register
memWrite  input  1  write request from EX/MEM control register
address  input  32  byte address (ALU result from EX/MEM)
writeData  input  32  store data (rt value from EX/MEM)
readData  output  32  load result; valid while done=1
hold  output  1  stall to all pipe registers and PC; 1 = freeze
done  output  1  access completes this cycle
err  output  1  sticky error flag: misaligned address or simultaneous read+write

Behaviour:
- Reset (rst=0, async): state IDLE, cnt=0, readData=0, hold=0, done=0, err=0, latched request cleared. Array contents are not reset.
- Word index is address[ADDR_W+1:2]. Upper bits are ignored, so out-of-range addresses wrap modulo 2**ADDR_W.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - hold is combinational: hold = memRead | memWrite.
  - On an edge with a request present: latch index, writeData and op (op=write if memWrite, else read); load cnt=LATENCY-1.
  - If LATENCY=1, go directly to DONE. Otherwise go to BUSY.
- BUSY:
  - hold=1.
  - cnt decrements each edge. When cnt=1 at the edge, go to DONE.
  - Request inputs are ignored; the latched copy is used.
- Entering DONE (same edge):
  - Write op: array[index] <= latched writeData.
  - Read op: readData <= array[index].
  - readData holds its last value after write ops.
- DONE:
  - hold=0, done=1.
  - The pipeline advances on this edge, and MEM/WB captures readData.
  - Always return to IDLE next edge. Request inputs seen during DONE belong to the completing instruction and are not re-issued.
- Timing: total stall = LATENCY cycles. A load's result reaches MEM/WB LATENCY+1 cycles after the request first appears.
- Back-to-back requests: the next instruction's request is sampled in the IDLE cycle after DONE. There is no extra bubble beyond that IDLE cycle's hold.
- memRead and memWrite both 1: err<=1 and the access is treated as a write.
- address[1:0] != 0: err<=1. Access proceeds word-aligned (low bits dropped).
- err is cleared only by reset.
- Reset asserted mid-access: abandon immediately, no array write, outputs return to reset values. A write pending in BUSY is lost.
- Array read is asynchronous internally. Array write is synchronous. The same address is never read and written in one edge, because the FSM serialises ops.

Decomposition:
- Shared package pipeline_pkg:
  - state encoding constants DMR_IDLE=2'd0, DMR_BUSY=2'd1, DMR_DONE=2'd2
  - WORD_W=32
  - op encoding OP_RD=1'b0, OP_WR=1'b1
- Sub-module dmem_array: parameter ADDR_W. Ports clk, we, waddr, wdata, raddr, rdata. Synchronous write, combinational read, no reset.
- FSM, counter and error logic live in dmem_stall_responder.

Test Plan:
- Reset, then hold memRead=memWrite=0 for 5 cycles -> hold=0, done=0, readData=0, err=0 throughout.
- LATENCY=2: write 0xDEADBEEF to 0x4, then read 0x4 -> hold=1 for exactly 2 cycles per access; done pulses 1 cycle; readData=0xDEADBEEF in the read's DONE cycle.
- LATENCY=1: store 0x00000005 to 0x8, then immediately load 0x8 -> 1 stall cycle each; readData=5; no duplicated write (counter on we pulses = 1).
- Set memRead=memWrite=1 at address 0x10 with data 0x12345678 -> err=1 and stays 1; a later read of 0x10 returns 0x12345678.
- Read at address 0x6 after writing 0xCAFEF00D to 0x4 -> err=1; readData=0xCAFEF00D.
- With LATENCY=4, start a write of 0xAAAAAAAA to 0x20 and pulse rst low in the second BUSY cycle -> hold drops immediately; readData=0; a later read of 0x20 returns the prior value, not 0xAAAAAAAA.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the data-memory stall responder
package pipeline_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_BUSY = 2'd1,
        DMR_DONE = 2'd2
    } dmr_state_t;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word array with synchronous write and combinational read
module dmem_array
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/dmem_stall_responder.sv
// dmem_stall_responder: multi-cycle data memory for the MEM stage; holds the pipe
// for LATENCY cycles per access and presents load data for one DONE cycle.
module dmem_stall_responder
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hold,
    output logic        done,
    output logic        err
);
    dmr_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d, idx;
    logic [WORD_W-1:0] wdata_q, wdata_d, wdat;
    logic [WORD_W-1:0] rdata_q, rdata_d, arr_rdata;
    logic              op_q, op_d, op;
    logic              err_q, err_d;
    logic              req, idle, finish, arr_we;
    logic              unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADDR_W+2];
    assign req  = memRead | memWrite;
    assign idle = state_q == DMR_IDLE;
    // In IDLE the live request is used so a LATENCY=1 access completes on its first edge
    assign idx  = idle ? address[ADDR_W+1:2] : idx_q;
    assign wdat = idle ? writeData : wdata_q;
    assign op   = idle ? (memWrite ? OP_WR : OP_RD) : op_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        finish  = 1'b0;
        hold    = 1'b0;
        case (state_q)
            DMR_IDLE: begin
                hold = req;
                if (req) begin
                    idx_d   = idx;
                    wdata_d = wdat;
                    op_d    = op;
                    cnt_d   = 4'(LATENCY - 1);
                    err_d   = err_q | (memRead & memWrite) | (address[1:0] != 2'b00);
                    finish  = LATENCY == 1;
                    state_d = finish ? DMR_DONE : DMR_BUSY;
                end
            end
            DMR_BUSY: begin
                hold    = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                finish  = cnt_q == 4'd1;
                state_d = finish ? DMR_DONE : DMR_BUSY;
            end
            default: state_d = DMR_IDLE;
        endcase
        arr_we = finish & (op == OP_WR) & rst;
        rdata_d = (finish & (op == OP_RD)) ? arr_rdata : rdata_q;
        hold = hold & rst;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMR_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_RD;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end
    dmem_array #(.ADDR_W(ADDR_W)) u_arr (
        .clk  (clk),
        .we   (arr_we),
        .waddr(idx),
        .wdata(wdat),
        .raddr(idx),
        .rdata(arr_rdata)
    );
    assign readData = rdata_q;
    assign done     = state_q == DMR_DONE;
    assign err      = err_q;
endmodule
